// File: rtl/jojo_hit_ctrl_pkg.sv
// jojo_hit_ctrl_pkg
// Shared game definitions for the player hit controller and its helpers.
//   hit_state_t    : player life state (ALIVE=0, INVULN=1, DEAD=2)
//   HP_MAX         : default health loaded at reset / restart
//   INVULN_FRAMES  : default invulnerability length in frames
//   BLINK_BIT      : default invulnerability-counter bit used for blinking
//   HP_W, CNT_W    : widths of the health value and frame counter
package jojo_hit_ctrl_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hit_state_t;

  localparam int unsigned HP_MAX        = 3;
  localparam int unsigned INVULN_FRAMES = 60;
  localparam int unsigned BLINK_BIT     = 2;
  localparam int unsigned HP_W          = 3;
  localparam int unsigned CNT_W         = 8;

endpackage

// File: rtl/jojo_hit_ctrl_frame_counter_down.sv
// frame_counter_down
// Loadable down-counter that steps once per frame. Shared with the enemy
// respawn timers.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : force count to zero (highest priority)
//   load        : load load_value
//   dec         : decrement by one, saturating at zero
//   count       : current count
//   count_next  : value count takes on the next clock edge
//   tc          : terminal count, high when count == 1 (next dec reaches 0)
module frame_counter_down #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         tc
);

  // count_next is exported so the owner can register outputs that depend on
  // the counter without adding a cycle of lag.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_value;
    end else if (dec && (count != '0)) begin
      count_next = count - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/jojo_hit_ctrl.sv
// jojo_hit_ctrl
// Player collision and health controller. Detects pixel-exact overlap of the
// player and any enemy during a frame and, at the next frame boundary, runs
// the health / invulnerability / game-over state machine.
//   clk, reset    : clock, asynchronous active-high reset
//   jojo_on       : player sprite opaque at current pixel
//   enemy_on      : OR of all enemy sprites' opaque flags at current pixel
//   frame_start   : one-cycle pulse at the start of each frame
//   restart       : one-cycle pulse that revives the player
//   hp            : current health, 0..HP_MAX
//   hit_pulse     : one-cycle pulse when health is decremented
//   invuln        : high while invulnerable
//   jojo_visible  : gate for the player sprite in the pixel mux
//   game_over     : high while dead
module jojo_hit_ctrl
  import jojo_hit_ctrl_pkg::*;
#(
  parameter int unsigned HP_MAX        = jojo_hit_ctrl_pkg::HP_MAX,
  parameter int unsigned INVULN_FRAMES = jojo_hit_ctrl_pkg::INVULN_FRAMES,
  parameter int unsigned BLINK_BIT     = jojo_hit_ctrl_pkg::BLINK_BIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            jojo_on,
  input  logic            enemy_on,
  input  logic            frame_start,
  input  logic            restart,
  output logic [HP_W-1:0] hp,
  output logic            hit_pulse,
  output logic            invuln,
  output logic            jojo_visible,
  output logic            game_over
);

  hit_state_t       state;
  hit_state_t       state_next;
  logic [HP_W-1:0]  hp_next;
  logic             hit_pulse_next;
  logic             invuln_next;
  logic             jojo_visible_next;
  logic             game_over_next;
  logic             hit_latch;
  logic             collide;
  logic             cnt_clear;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] inv_cnt;
  logic [CNT_W-1:0] inv_cnt_next;
  logic             inv_tc;

  assign collide = jojo_on & enemy_on;

  // A collide coinciding with frame_start belongs to the new frame, so the
  // latch reloads with that cycle's collide instead of simply clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_latch <= 1'b0;
    end else if (restart) begin
      hit_latch <= 1'b0;
    end else if (frame_start) begin
      hit_latch <= collide;
    end else if (collide) begin
      hit_latch <= 1'b1;
    end
  end

  frame_counter_down #(
    .W(CNT_W)
  ) u_inv_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_value (CNT_W'(INVULN_FRAMES)),
    .dec        (cnt_dec),
    .count      (inv_cnt),
    .count_next (inv_cnt_next),
    .tc         (inv_tc)
  );

  // restart outranks frame_start; every transition waits for one of them.
  always_comb begin
    state_next     = state;
    hp_next        = hp;
    hit_pulse_next = 1'b0;
    cnt_clear      = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    if (restart) begin
      state_next = ALIVE;
      hp_next    = HP_W'(HP_MAX);
      cnt_clear  = 1'b1;
    end else if (frame_start) begin
      case (state)
        ALIVE: begin
          if (hit_latch && (hp != '0)) begin
            hp_next        = hp - HP_W'(1);
            hit_pulse_next = 1'b1;
            if (hp == HP_W'(1)) begin
              state_next = DEAD;
            end else begin
              state_next = INVULN;
              cnt_load   = 1'b1;
            end
          end
        end
        INVULN: begin
          cnt_dec = 1'b1;
          if (inv_tc) begin
            state_next = ALIVE;
          end
        end
        DEAD: begin
          state_next = DEAD;
        end
        default: begin
          state_next = ALIVE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they can be registered and
  // still line up with the state register.
  always_comb begin
    invuln_next       = (state_next == INVULN);
    game_over_next    = (state_next == DEAD);
    jojo_visible_next = 1'b1;
    case (state_next)
      ALIVE:   jojo_visible_next = 1'b1;
      INVULN:  jojo_visible_next = inv_cnt_next[BLINK_BIT];
      DEAD:    jojo_visible_next = 1'b0;
      default: jojo_visible_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ALIVE;
      hp           <= HP_W'(HP_MAX);
      hit_pulse    <= 1'b0;
      invuln       <= 1'b0;
      jojo_visible <= 1'b1;
      game_over    <= 1'b0;
    end else begin
      state        <= state_next;
      hp           <= hp_next;
      hit_pulse    <= hit_pulse_next;
      invuln       <= invuln_next;
      jojo_visible <= jojo_visible_next;
      game_over    <= game_over_next;
    end
  end

endmodule

// File: tb/tb_jojo_hit_ctrl.sv
// tb_jojo_hit_ctrl
// Directed bench for jojo_hit_ctrl with default parameters
// (HP_MAX=3, INVULN_FRAMES=60, BLINK_BIT=2).
module tb_jojo_hit_ctrl;

  logic       clk;
  logic       reset;
  logic       jojo_on;
  logic       enemy_on;
  logic       frame_start;
  logic       restart;
  logic [2:0] hp;
  logic       hit_pulse;
  logic       invuln;
  logic       jojo_visible;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  jojo_hit_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .jojo_on      (jojo_on),
    .enemy_on     (enemy_on),
    .frame_start  (frame_start),
    .restart      (restart),
    .hp           (hp),
    .hit_pulse    (hit_pulse),
    .invuln       (invuln),
    .jojo_visible (jojo_visible),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic collide_cycle();
    jojo_on  = 1'b1;
    enemy_on = 1'b1;
    cyc();
    jojo_on  = 1'b0;
    enemy_on = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++; if (hp !== 3'd3) begin errors++; $display("[TB] FAIL reset_hp got %0d want 3", hp); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit_pulse got %0b want 0", hit_pulse); end
    checks++; if (invuln !== 1'b0) begin errors++; $display("[TB] FAIL reset_invuln got %0b want 0", invuln); end
    checks++; if (jojo_visible !== 1'b1) begin errors++; $display("[TB] FAIL reset_visible got %0b want 1", jojo_visible); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL reset_game_over got %0b want 0", game_over); end
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      pulse_frame();
      checks++; if (hp !== 3'd3) begin errors++; $display("[TB] FAIL idle_hp frame %0d got %0d want 3", i, hp); end
      checks++; if (jojo_visible !== 1'b1) begin errors++; $display("[TB] FAIL idle_visible frame %0d got %0b want 1", i, jojo_visible); end
      checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL idle_hit_pulse frame %0d got %0b want 0", i, hit_pulse); end
    end
  endtask

  task automatic test_single_hit();
    int c;
    logic exp_vis;
    collide_cycle();
    cyc();
    pulse_frame();
    checks++; if (hp !== 3'd2) begin errors++; $display("[TB] FAIL hit_hp got %0d want 2", hp); end
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("[TB] FAIL hit_pulse_high got %0b want 1", hit_pulse); end
    checks++; if (invuln !== 1'b1) begin errors++; $display("[TB] FAIL hit_invuln got %0b want 1", invuln); end
    checks++; if (jojo_visible !== 1'b1) begin errors++; $display("[TB] FAIL hit_visible got %0b want 1", jojo_visible); end
    cyc();
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL hit_pulse_width got %0b want 0", hit_pulse); end
    // Collide is held throughout invulnerability, released only for the
    // final frame_start so the new frame starts without a pending hit.
    for (int k = 1; k <= 60; k++) begin
      jojo_on  = 1'b1;
      enemy_on = 1'b1;
      cyc();
      if (k == 60) begin
        jojo_on  = 1'b0;
        enemy_on = 1'b0;
      end
      pulse_frame();
      checks++; if (hp !== 3'd2) begin errors++; $display("[TB] FAIL inv_hp frame %0d got %0d want 2", k, hp); end
      checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL inv_hit_pulse frame %0d got %0b want 0", k, hit_pulse); end
      if (k < 60) begin
        c = 60 - k;
        exp_vis = ((c >> 2) & 1) != 0;
        checks++; if (invuln !== 1'b1) begin errors++; $display("[TB] FAIL inv_invuln frame %0d got %0b want 1", k, invuln); end
        checks++; if (jojo_visible !== exp_vis) begin errors++; $display("[TB] FAIL inv_blink frame %0d got %0b want %0b", k, jojo_visible, exp_vis); end
      end else begin
        checks++; if (invuln !== 1'b0) begin errors++; $display("[TB] FAIL inv_expire got %0b want 0", invuln); end
        checks++; if (jojo_visible !== 1'b1) begin errors++; $display("[TB] FAIL inv_expire_visible got %0b want 1", jojo_visible); end
      end
    end
    jojo_on  = 1'b0;
    enemy_on = 1'b0;
    cyc();
    pulse_frame();
    checks++; if (hp !== 3'd2) begin errors++; $display("[TB] FAIL post_inv_hp got %0d want 2", hp); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL post_inv_hit_pulse got %0b want 0", hit_pulse); end
  endtask

  task automatic test_to_dead();
    collide_cycle();
    pulse_frame();
    checks++; if (hp !== 3'd1) begin errors++; $display("[TB] FAIL second_hit_hp got %0d want 1", hp); end
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("[TB] FAIL second_hit_pulse got %0b want 1", hit_pulse); end
    for (int k = 1; k <= 60; k++) begin
      pulse_frame();
    end
    checks++; if (invuln !== 1'b0) begin errors++; $display("[TB] FAIL second_expire got %0b want 0", invuln); end
    collide_cycle();
    pulse_frame();
    checks++; if (hp !== 3'd0) begin errors++; $display("[TB] FAIL third_hit_hp got %0d want 0", hp); end
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("[TB] FAIL third_hit_pulse got %0b want 1", hit_pulse); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("[TB] FAIL dead_game_over got %0b want 1", game_over); end
    checks++; if (jojo_visible !== 1'b0) begin errors++; $display("[TB] FAIL dead_visible got %0b want 0", jojo_visible); end
    checks++; if (invuln !== 1'b0) begin errors++; $display("[TB] FAIL dead_invuln got %0b want 0", invuln); end
    collide_cycle();
    pulse_frame();
    checks++; if (hp !== 3'd0) begin errors++; $display("[TB] FAIL dead_hp_floor got %0d want 0", hp); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL dead_no_pulse got %0b want 0", hit_pulse); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("[TB] FAIL dead_stays got %0b want 1", game_over); end
  endtask

  task automatic test_restart_dead();
    collide_cycle();
    restart     = 1'b1;
    frame_start = 1'b1;
    cyc();
    restart     = 1'b0;
    frame_start = 1'b0;
    checks++; if (hp !== 3'd3) begin errors++; $display("[TB] FAIL restart_hp got %0d want 3", hp); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL restart_game_over got %0b want 0", game_over); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL restart_pulse got %0b want 0", hit_pulse); end
    checks++; if (jojo_visible !== 1'b1) begin errors++; $display("[TB] FAIL restart_visible got %0b want 1", jojo_visible); end
    checks++; if (invuln !== 1'b0) begin errors++; $display("[TB] FAIL restart_invuln got %0b want 0", invuln); end
    cyc();
    pulse_frame();
    checks++; if (hp !== 3'd3) begin errors++; $display("[TB] FAIL restart_latch_clear got %0d want 3", hp); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL restart_latch_pulse got %0b want 0", hit_pulse); end
  endtask

  task automatic test_same_cycle_collide();
    jojo_on  = 1'b1;
    enemy_on = 1'b1;
    pulse_frame();
    jojo_on  = 1'b0;
    enemy_on = 1'b0;
    checks++; if (hp !== 3'd3) begin errors++; $display("[TB] FAIL same_cycle_hp got %0d want 3", hp); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_pulse got %0b want 0", hit_pulse); end
    cyc();
    pulse_frame();
    checks++; if (hp !== 3'd2) begin errors++; $display("[TB] FAIL deferred_hit_hp got %0d want 2", hp); end
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("[TB] FAIL deferred_hit_pulse got %0b want 1", hit_pulse); end
    checks++; if (invuln !== 1'b1) begin errors++; $display("[TB] FAIL deferred_invuln got %0b want 1", invuln); end
  endtask

  task automatic test_async_reset();
    for (int k = 1; k <= 30; k++) begin
      pulse_frame();
    end
    checks++; if (invuln !== 1'b1) begin errors++; $display("[TB] FAIL mid_inv_invuln got %0b want 1", invuln); end
    checks++; if (jojo_visible !== 1'b1) begin errors++; $display("[TB] FAIL mid_inv_visible got %0b want 1", jojo_visible); end
    collide_cycle();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (hp !== 3'd3) begin errors++; $display("[TB] FAIL async_hp got %0d want 3", hp); end
    checks++; if (invuln !== 1'b0) begin errors++; $display("[TB] FAIL async_invuln got %0b want 0", invuln); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL async_game_over got %0b want 0", game_over); end
    checks++; if (jojo_visible !== 1'b1) begin errors++; $display("[TB] FAIL async_visible got %0b want 1", jojo_visible); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL async_pulse got %0b want 0", hit_pulse); end
    reset = 1'b0;
    cyc();
    pulse_frame();
    checks++; if (hp !== 3'd3) begin errors++; $display("[TB] FAIL async_latch_discard got %0d want 3", hp); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("[TB] FAIL async_latch_pulse got %0b want 0", hit_pulse); end
    checks++; if (invuln !== 1'b0) begin errors++; $display("[TB] FAIL async_stays_alive got %0b want 0", invuln); end
  endtask

  initial begin
    jojo_on     = 1'b0;
    enemy_on    = 1'b0;
    frame_start = 1'b0;
    restart     = 1'b0;
    reset       = 1'b1;
    test_reset();
    test_single_hit();
    test_to_dead();
    test_restart_dead();
    test_same_cycle_collide();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got no_finish want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
